// File: rtl/quad_pkg.sv
// quad_pkg: shared types and helpers for the quadrature generator.
// FSM state enum, minimum step period, phase-to-A/B encoder.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MIN_PERIOD = 2;

  // {A,B} for a 2-bit phase; forward order 00,10,11,01
  function automatic logic [1:0] ab_encode(
    input logic [1:0] p
  );
    return {p[1] ^ p[0], p[1]};
  endfunction

endpackage

// File: rtl/quad_tick.sv
// quad_tick: step-period divider, one-cycle tick at terminal count.
// in: clk, rst_n, run, enable, period; out: tick.
module quad_tick
  import quad_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] term;

  // period 0/1 clamp to MIN_PERIOD so edges stay >= 2 cycles apart
  assign term = (period < DIV_W'(MIN_PERIOD))
              ? DIV_W'(MIN_PERIOD - 1)
              : period - DIV_W'(1);

  assign tick = run & enable & (div_q == term);

  // a shrunk period leaves div_q past term: wrap with no tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (!run) begin
      div_q <= '0;
    end else if (enable) begin
      if (div_q >= term) div_q <= '0;
      else               div_q <= div_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/quad_gen.sv
// quad_gen: drives quadA/quadB edges until position reaches target.
// in: clk, rst_n, enable, target, target_valid, period; out: quadA, quadB, position, busy, done.
module quad_gen
  import quad_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int DIV_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic signed [CNT_W-1:0] target,
  input  logic                    target_valid,
  input  logic        [DIV_W-1:0] period,
  output logic                    quadA,
  output logic                    quadB,
  output logic signed [CNT_W-1:0] position,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_q;
  state_e                  state_d;
  logic              [1:0] phase_q;
  logic              [1:0] phase_d;
  logic signed [CNT_W-1:0] pos_d;
  logic signed [CNT_W-1:0] tgt_q;
  logic signed [CNT_W-1:0] tgt_d;
  logic                    done_d;
  logic                    fwd;
  logic                    run;
  logic                    tick;
  logic              [1:0] ab_d;

  assign run = (state_q == RUN);

  quad_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .enable (enable),
    .period (period),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pos_d   = position;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    fwd     = (tgt_q > position);
    unique case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d = target;
          if (target != position) state_d = RUN;
        end
      end
      RUN: begin
        // edge direction uses the target held before any new strobe
        if (tick) begin
          if (fwd) begin
            phase_d = phase_q + 2'd1;
            pos_d   = position + CNT_W'(1);
          end else begin
            phase_d = phase_q - 2'd1;
            pos_d   = position - CNT_W'(1);
          end
        end
        if (target_valid) tgt_d = target;
        if (pos_d == tgt_d) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ab_d = ab_encode(phase_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      phase_q  <= 2'd0;
      position <= '0;
      tgt_q    <= '0;
      quadA    <= 1'b0;
      quadB    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      position <= pos_d;
      tgt_q    <= tgt_d;
      quadA    <= ab_d[1];
      quadB    <= ab_d[0];
      busy     <= (state_d == RUN);
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: scoreboard bench for quad_gen with a loopback decoder.
// Expected edges/done pulses are queued at each strobe, popped on output.
module tb_quad_gen;

  localparam logic [1:0] SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct {
    int         cyc;
    logic [1:0] ab;
    int         pos;
  } edge_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b0;
  logic               target_valid = 1'b0;
  logic signed [31:0] target = '0;
  logic        [15:0] period = 16'd4;
  logic               quadA;
  logic               quadB;
  logic               busy;
  logic               done;
  logic signed [31:0] position;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dec = 0;
  logic [1:0] prev_ab = 2'b00;
  edge_t exp_q[$];
  int    done_q[$];

  quad_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .target       (target),
    .target_valid (target_valid),
    .period       (period),
    .quadA        (quadA),
    .quadB        (quadB),
    .position     (position),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ab_idx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++)
      if (SEQ[i] == ab) return i;
    return 0;
  endfunction

  always @(negedge clk) begin : mon
    logic [1:0] cur;
    edge_t      e;
    int         d;
    if (!rst_n) begin
      prev_ab = 2'b00;
      dec     = 0;
    end else begin
      cur = {quadA, quadB};
      if (cur !== prev_ab) begin
        chk("single_toggle", $countones(cur ^ prev_ab), 1);
        d = (ab_idx(cur) - ab_idx(prev_ab)) & 3;
        if (d == 1) dec++;
        else if (d == 3) dec--;
        chk("edge_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("edge_cycle", cyc, e.cyc);
          chk("edge_ab", cur, e.ab);
          chk("edge_pos", position, e.pos);
        end
        prev_ab = cur;
      end
      if (done) begin
        chk("done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic strobe(input int t, output int s);
    target       = t;
    target_valid = 1'b1;
    s            = cyc + 1;
    @(negedge clk);
    target_valid = 1'b0;
  endtask

  task automatic push_seq(input int from, input int to, input int eff,
                          input int base, input bit with_done);
    int    n;
    int    dir;
    edge_t e;
    n   = (to > from) ? to - from : from - to;
    dir = (to > from) ? 1 : -1;
    for (int i = 1; i <= n; i++) begin
      e.cyc = base + i * eff;
      e.pos = from + dir * i;
      e.ab  = SEQ[e.pos & 3];
      exp_q.push_back(e);
    end
    if (with_done) done_q.push_back(base + n * eff);
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() > 0 || done_q.size() > 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size() + done_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int s;
    int base;
    enable = 1'b1;
    period = 16'd4;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_quadA", quadA, 0);
    chk("idle_quadB", quadB, 0);
    chk("idle_pos", position, 0);
    chk("idle_busy", busy, 0);

    strobe(5, s);
    push_seq(0, 5, 4, s, 1);
    chk("busy_run", busy, 1);
    drain(200);
    chk("pos_p5", position, 5);
    chk("dec_p5", dec, 5);
    chk("busy_idle", busy, 0);

    strobe(-3, s);
    push_seq(5, -3, 4, s, 1);
    drain(200);
    chk("pos_m3", position, -3);
    chk("dec_m3", dec, -3);

    period = 16'd3;
    strobe(100, s);
    base = s + 39;
    push_seq(-3, 10, 3, s, 0);
    while (cyc < base) @(negedge clk);
    chk("pos_at_10", position, 10);
    strobe(7, s);
    push_seq(10, 7, 3, base, 1);
    drain(200);
    chk("pos_retarget", position, 7);
    chk("busy_retarget", busy, 0);
    chk("dec_retarget", dec, 7);

    period = 16'd4;
    strobe(12, s);
    push_seq(7, 9, 4, s, 0);
    push_seq(9, 12, 4, s + 58, 1);
    while (cyc < s + 9) @(negedge clk);
    enable = 1'b0;
    repeat (25) @(negedge clk);
    chk("pos_frozen", position, 9);
    chk("busy_frozen", busy, 1);
    while (cyc < s + 59) @(negedge clk);
    enable = 1'b1;
    drain(200);
    chk("pos_resume", position, 12);

    period = 16'd0;
    strobe(15, s);
    push_seq(12, 15, 2, s, 1);
    drain(100);
    chk("pos_p0", position, 15);

    period = 16'd1;
    strobe(13, s);
    push_seq(15, 13, 2, s, 1);
    drain(100);
    chk("pos_p1", position, 13);

    period = 16'd4;
    strobe(30, s);
    push_seq(13, 30, 4, s, 1);
    while (cyc < s + 9) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    done_q.delete();
    chk("arst_quadA", quadA, 0);
    chk("arst_quadB", quadB, 0);
    chk("arst_pos", position, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_pos", position, 0);
    period = 16'd2;
    strobe(3, s);
    push_seq(0, 3, 2, s, 1);
    drain(100);
    chk("post_rst_p3", position, 3);
    chk("post_rst_dec", dec, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
